zap_ifetch_ctrl: RTL and testbench

- Instruction fetch controller directly upstream of the fetch-side instruction FIFO (zap_fifo).
- Generates sequential word-aligned fetch addresses and issues pipelined, in-order requests on a req/gnt/rvalid instruction bus.
- Buffers returning words in a local skid store and pushes {abort, pc, instr} packets into the FIFO only while the FIFO is not full.
- Handles PC redirects (branch/exception) by flushing local state and discarding responses from stale in-flight requests.

---
 rtl/zap_ifetch_ctrl_pkg.sv | 20 ++
 rtl/zap_ifetch_ctrl_if.sv | 26 ++
 rtl/zap_ifetch_skid.sv | 77 +++++++
 rtl/zap_ifetch_ctrl.sv | 132 +++++++++++++
 tb/tb_zap_ifetch_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zap_ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its FIFO hookup.
package zap_ifetch_ctrl_pkg;

    localparam int FETCH_PKT_W = 65;

    typedef struct packed {
        logic        abort;
        logic [31:0] pc;
        logic [31:0] instr;
    } zap_fetch_pkt_t;

    // Counters must hold the value MAX_OUT itself, not just MAX_OUT-1.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int DEFAULT_MAX_OUT = 2;
    localparam int DEFAULT_CNT_W   = cnt_width(DEFAULT_MAX_OUT);

endpackage

// File: rtl/zap_ifetch_ctrl_if.sv
// Instruction bus and FIFO-side signals of the fetch controller.
interface zap_ifetch_ctrl_if
    import zap_ifetch_ctrl_pkg::*;
#(
    parameter int PKT_W = FETCH_PKT_W
);
    logic             o_req;
    logic [31:0]      o_addr;
    logic             i_gnt;
    logic             i_rvalid;
    logic [31:0]      i_rdata;
    logic             i_rerr;
    logic             i_fifo_full;
    logic [PKT_W-1:0] o_pkt;
    logic             o_valid;

    modport master (
        output o_req, o_addr, o_pkt, o_valid,
        input  i_gnt, i_rvalid, i_rdata, i_rerr, i_fifo_full
    );

    modport slave (
        input  o_req, o_addr, o_pkt, o_valid,
        output i_gnt, i_rvalid, i_rdata, i_rerr, i_fifo_full
    );
endinterface

// File: rtl/zap_ifetch_skid.sv
// Small synchronous FIFO with clear, count and a combinational head; used for packets and pc tags.
module zap_ifetch_skid #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (i_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Storage is zeroed on reset so the head reads as all-zero until the first push.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_push && !i_pop && !i_clear && count_q == FULL_CNT));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_pop && !i_clear && count_q == '0));

endmodule

// File: rtl/zap_ifetch_ctrl.sv
// Fetch controller: issues in-order word fetches, tags responses with their pc and feeds the instruction FIFO.
module zap_ifetch_ctrl
    import zap_ifetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MAX_OUT      = 2,
    parameter int          PKT_W        = FETCH_PKT_W
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_load,
    input  logic [31:0] i_pc_new,
    input  logic        i_halt,
    zap_ifetch_ctrl_if.master bus
);

    localparam int CNT_W = cnt_width(MAX_OUT);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(MAX_OUT);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] skid_cnt;
    logic             skid_empty;
    logic             skid_push;
    logic [PKT_W-1:0] skid_wvec;
    logic [PKT_W-1:0] skid_head;
    zap_fetch_pkt_t   skid_wdata;

    logic [CNT_W-1:0] tag_cnt;
    logic             tag_empty;
    logic [31:0]      tag_head;

    logic [CNT_W:0]   credit_used;
    logic             issue_ok;
    logic             grant;
    logic             discard;
    logic [31:0]      pc_new_aligned;

    assign pc_new_aligned = i_pc_new & 32'hFFFF_FFFC;
    assign credit_used    = {1'b0, out_cnt_q} + {1'b0, skid_cnt};

    always_comb begin
        issue_ok = !i_reset && !i_pc_load && !i_halt && (credit_used < CREDIT_LIMIT);
        grant    = issue_ok && bus.i_gnt;
        discard  = (drop_cnt_q != '0) || i_pc_load;
        skid_push = bus.i_rvalid && !discard;

        skid_wdata.abort = bus.i_rerr;
        skid_wdata.pc    = tag_head;
        skid_wdata.instr = bus.i_rerr ? 32'h0 : bus.i_rdata;
        skid_wvec        = PKT_W'(skid_wdata);

        bus.o_req   = issue_ok;
        bus.o_addr  = pc_q;
        bus.o_valid = !skid_empty && !bus.i_fifo_full && !i_pc_load;
        bus.o_pkt   = skid_head;
    end

    // A redirect snapshots every live request as stale; a response arriving in the
    // redirect cycle is dropped on the spot, so it is excluded from the snapshot.
    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + CNT_W'(grant) - CNT_W'(bus.i_rvalid);
        drop_cnt_d = drop_cnt_q;
        if (i_pc_load) begin
            pc_d       = pc_new_aligned;
            drop_cnt_d = out_cnt_q - CNT_W'(bus.i_rvalid);
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (bus.i_rvalid && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q       <= RESET_VECTOR;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    zap_ifetch_skid #(
        .WIDTH (PKT_W),
        .DEPTH (MAX_OUT)
    ) u_pkt_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_pc_load),
        .i_push  (skid_push),
        .i_wdata (skid_wvec),
        .i_pop   (bus.o_valid),
        .o_head  (skid_head),
        .o_count (skid_cnt),
        .o_empty (skid_empty)
    );

    // Tags survive a redirect: stale tags leave together with their dropped responses.
    zap_ifetch_skid #(
        .WIDTH (32),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (1'b0),
        .i_push  (grant),
        .i_wdata (pc_q),
        .i_pop   (bus.i_rvalid),
        .o_head  (tag_head),
        .o_count (tag_cnt),
        .o_empty (tag_empty)
    );

    a_rvalid_needs_outstanding: assert property (@(posedge i_clk) disable iff (i_reset)
        !(bus.i_rvalid && (out_cnt_q == '0 || tag_empty)));
    a_addr_aligned: assert property (@(posedge i_clk) disable iff (i_reset)
        bus.o_addr[1:0] == 2'b00);
    a_drop_bounded: assert property (@(posedge i_clk) disable iff (i_reset)
        drop_cnt_q <= out_cnt_q);
    a_tags_track_requests: assert property (@(posedge i_clk) disable iff (i_reset)
        tag_cnt == out_cnt_q);

endmodule

// File: tb/tb_zap_ifetch_ctrl.sv
// Bench for zap_ifetch_ctrl: directed vector table, then randomized bus traffic against a stream-level model.
module tb_zap_ifetch_ctrl;
    import zap_ifetch_ctrl_pkg::*;

    localparam int          MAX_OUT      = 2;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic        H            = 1'b1;
    localparam logic        L            = 1'b0;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_pc_load;
    logic [31:0] i_pc_new;
    logic        i_halt;

    int tests_run    = 0;
    int tests_failed = 0;

    zap_ifetch_ctrl_if #(.PKT_W(FETCH_PKT_W)) bus ();

    zap_ifetch_ctrl #(
        .RESET_VECTOR (RESET_VECTOR),
        .MAX_OUT      (MAX_OUT),
        .PKT_W        (FETCH_PKT_W)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_pc_load (i_pc_load),
        .i_pc_new  (i_pc_new),
        .i_halt    (i_halt),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [31:0] pc_new;
        logic        halt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rerr;
        logic        full;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        exp_abort;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[22];

    // Bus-side model: addresses granted and not yet answered, in order.
    logic [31:0] inflight[$];
    logic [31:0] m_issue_pc;
    logic [31:0] m_pkt_pc;
    int          live_grants;
    int          delivered;
    int          total_grants;
    logic        last_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'hB;
    endfunction

    task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        i_pc_load       = 1'b0;
        i_pc_new        = 32'h0;
        i_halt          = 1'b0;
        bus.i_gnt       = 1'b0;
        bus.i_rvalid    = 1'b0;
        bus.i_rdata     = 32'h0;
        bus.i_rerr      = 1'b0;
        bus.i_fifo_full = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        i_reset = 1'b1;
        idleInputs();
        @(posedge clk); #4;
        checkOutput("reset_req", bus.o_req, 1'b0);
        checkOutput("reset_valid", bus.o_valid, 1'b0);
        checkOutput("reset_pkt", bus.o_pkt, '0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        #4;
        checkOutput("reset_addr", bus.o_addr, RESET_VECTOR);
        inflight.delete();
        m_issue_pc  = RESET_VECTOR;
        m_pkt_pc    = RESET_VECTOR;
        live_grants = 0;
        delivered   = 0;
    endtask

    // One cycle of bus traffic; expected behaviour comes from the fetch-stream rules,
    // not from the controller's counters.
    task automatic applyStimulus(input logic load, input logic [31:0] pc_new, input logic halt,
                                 input logic gnt, input logic rv_en, input logic full);
        zap_fetch_pkt_t p;
        logic           rv;
        @(posedge clk); #1;
        rv              = rv_en && (inflight.size() > 0);
        i_pc_load       = load;
        i_pc_new        = pc_new;
        i_halt          = halt;
        bus.i_gnt       = gnt;
        bus.i_rvalid    = rv;
        bus.i_rdata     = rv ? mem_word(inflight[0]) : 32'h0;
        bus.i_rerr      = rv ? mem_err(inflight[0]) : 1'b0;
        bus.i_fifo_full = full;
        #4;
        last_req = bus.o_req;
        if (load) begin
            checkOutput("redirect_req", bus.o_req, 1'b0);
            checkOutput("redirect_valid", bus.o_valid, 1'b0);
        end else if (bus.o_req) begin
            checkOutput("issue_addr", bus.o_addr, m_issue_pc);
        end
        if (halt) checkOutput("halt_req", bus.o_req, 1'b0);
        if (full) checkOutput("full_blocks_valid", bus.o_valid, 1'b0);
        if (bus.o_valid) begin
            p = bus.o_pkt;
            checkOutput("pkt_pc", p.pc, m_pkt_pc);
            checkOutput("pkt_abort", p.abort, mem_err(m_pkt_pc));
            checkOutput("pkt_instr", p.instr, mem_err(m_pkt_pc) ? 32'h0 : mem_word(m_pkt_pc));
            m_pkt_pc = m_pkt_pc + 32'd4;
            delivered++;
        end
        if (bus.o_req && gnt) begin
            inflight.push_back(bus.o_addr);
            m_issue_pc = m_issue_pc + 32'd4;
            live_grants++;
            total_grants++;
        end
        if (rv) void'(inflight.pop_front());
        if (load) begin
            m_issue_pc  = pc_new & 32'hFFFF_FFFC;
            m_pkt_pc    = pc_new & 32'hFFFF_FFFC;
            live_grants = 0;
            delivered   = 0;
        end
        checkOutput("outstanding_bound", 65'(inflight.size() > MAX_OUT), 65'd0);
    endtask

    initial begin
        int grants_before;
        i_reset = 1'b1;
        idleInputs();
        total_grants = 0;
        last_req     = 1'b0;

        vecs[0]  = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'h0000_0000, L, L, 32'h0,         32'h0};
        vecs[1]  = '{L, 32'h0,        L, H, H, 32'hC0DE_0000, L, L, H, 32'h0000_0004, L, L, 32'h0,         32'h0};
        vecs[2]  = '{L, 32'h0,        L, H, H, 32'hC0DE_0004, L, L, L, 32'h0000_0008, H, L, 32'h0,         32'hC0DE_0000};
        vecs[3]  = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'h0000_0008, H, L, 32'h4,         32'hC0DE_0004};
        vecs[4]  = '{L, 32'h0,        L, H, H, 32'hDEAD_BEEF, H, L, H, 32'h0000_000C, L, L, 32'h0,         32'h0};
        vecs[5]  = '{L, 32'h0,        L, L, L, 32'h0,        L, H, L, 32'h0000_0010, L, L, 32'h0,         32'h0};
        vecs[6]  = '{L, 32'h0,        L, L, L, 32'h0,        L, L, L, 32'h0000_0010, H, H, 32'h8,         32'h0};
        vecs[7]  = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'h0000_0010, L, L, 32'h0,         32'h0};
        vecs[8]  = '{H, 32'h1003,     L, H, L, 32'h0,        L, L, L, 32'h0000_0014, L, L, 32'h0,         32'h0};
        vecs[9]  = '{L, 32'h0,        L, H, H, 32'hBAD0_BAD0, L, L, L, 32'h0000_1000, L, L, 32'h0,         32'h0};
        vecs[10] = '{L, 32'h0,        L, H, H, 32'hBAD0_BAD0, L, L, H, 32'h0000_1000, L, L, 32'h0,         32'h0};
        vecs[11] = '{L, 32'h0,        L, L, H, 32'hE000_1000, L, L, H, 32'h0000_1004, L, L, 32'h0,         32'h0};
        vecs[12] = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'h0000_1004, H, L, 32'h1000,      32'hE000_1000};
        vecs[13] = '{H, 32'h2000,     L, H, H, 32'hBAD0_BAD0, L, L, L, 32'h0000_1008, L, L, 32'h0,         32'h0};
        vecs[14] = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'h0000_2000, L, L, 32'h0,         32'h0};
        vecs[15] = '{L, 32'h0,        L, L, H, 32'hE000_2000, L, L, H, 32'h0000_2004, L, L, 32'h0,         32'h0};
        vecs[16] = '{L, 32'h0,        H, H, L, 32'h0,        L, L, L, 32'h0000_2004, H, L, 32'h2000,      32'hE000_2000};
        vecs[17] = '{H, 32'hFFFF_FFFF, L, L, L, 32'h0,        L, L, L, 32'h0000_2004, L, L, 32'h0,         32'h0};
        vecs[18] = '{L, 32'h0,        L, H, L, 32'h0,        L, L, H, 32'hFFFF_FFFC, L, L, 32'h0,         32'h0};
        vecs[19] = '{L, 32'h0,        L, L, L, 32'h0,        L, L, H, 32'h0000_0000, L, L, 32'h0,         32'h0};
        vecs[20] = '{L, 32'h0,        H, L, H, 32'hE000_FFFC, L, L, L, 32'h0000_0000, L, L, 32'h0,         32'h0};
        vecs[21] = '{L, 32'h0,        H, L, L, 32'h0,        L, L, L, 32'h0000_0000, H, L, 32'hFFFF_FFFC, 32'hE000_FFFC};

        doReset();

        for (int i = 0; i < 22; i++) begin
            zap_fetch_pkt_t p;
            @(posedge clk); #1;
            i_pc_load       = vecs[i].load;
            i_pc_new        = vecs[i].pc_new;
            i_halt          = vecs[i].halt;
            bus.i_gnt       = vecs[i].gnt;
            bus.i_rvalid    = vecs[i].rv;
            bus.i_rdata     = vecs[i].rdata;
            bus.i_rerr      = vecs[i].rerr;
            bus.i_fifo_full = vecs[i].full;
            #4;
            checkOutput($sformatf("vec%0d_req", i), bus.o_req, vecs[i].exp_req);
            checkOutput($sformatf("vec%0d_addr", i), bus.o_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_valid", i), bus.o_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                p = bus.o_pkt;
                checkOutput($sformatf("vec%0d_abort", i), p.abort, vecs[i].exp_abort);
                checkOutput($sformatf("vec%0d_pkt_pc", i), p.pc, vecs[i].exp_pc);
                checkOutput($sformatf("vec%0d_instr", i), p.instr, vecs[i].exp_instr);
            end
        end

        // FIFO held full: credit runs out after MAX_OUT words, then nothing is lost on release.
        doReset();
        grants_before = total_grants;
        for (int c = 0; c < 10; c++) applyStimulus(L, 32'h0, L, H, H, H);
        checkOutput("full_credit_grants", 65'(total_grants - grants_before), 65'(MAX_OUT));
        checkOutput("full_credit_req_low", last_req, 1'b0);
        for (int c = 0; c < 8; c++) applyStimulus(L, 32'h0, L, H, H, L);
        checkOutput("full_release_flow", 65'(delivered >= 4), 65'd1);

        // Randomized traffic, with a reset dropped in halfway.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] tgt;
            if (c == 300) doReset();
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            applyStimulus($urandom_range(0, 19) == 0, tgt, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) == 0);
        end

        for (int c = 0; c < 40; c++) begin
            if (inflight.size() == 0 && delivered == live_grants) break;
            applyStimulus(L, 32'h0, H, L, H, L);
        end
        checkOutput("drain_inflight", 65'(inflight.size()), 65'd0);
        checkOutput("drain_complete", 65'(delivered), 65'(live_grants));
        checkOutput("random_made_progress", 65'(total_grants > 100), 65'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
